// File: rtl/shift_chain_tx_if.sv
// Bus between a word producer / serial-chain receiver and the shift_chain_tx
// transmitter. The transmitter sits on the slave side: it consumes the
// valid/data_in handshake and drives the serial chain strobes.
interface shift_chain_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             ready;
    logic             sdata;
    logic             sclk;
    logic             latch;
    logic             busy;

    // Producer / receiver side
    modport master (
        output data_in, valid,
        input  ready, sdata, sclk, latch, busy
    );

    // Transmitter side
    modport slave (
        input  data_in, valid,
        output ready, sdata, sclk, latch, busy
    );
endinterface

// File: rtl/shift_chain_tx.sv
// Parallel-in/serial-out transmitter for a chain of D flip-flops.
// A word accepted over valid/ready is shifted out on sdata with an sclk
// strobe (DIV cycles low, DIV cycles high per bit), followed by a latch
// pulse of DIV cycles. All outputs come straight from registers.
module shift_chain_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    shift_chain_tx_if.slave  bus
);
    localparam int BW   = $clog2(WIDTH + 1);
    localparam int DW   = $clog2(DIV + 1);
    localparam int HEAD = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shreg_reg, shreg_next;
    logic [WIDTH-1:0] shreg_adv;
    logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [DW-1:0]    div_cnt_reg, div_cnt_next;
    logic             ready_reg, ready_next;
    logic             busy_reg, busy_next;
    logic             sdata_reg, sdata_next;
    logic             sclk_reg, sclk_next;
    logic             latch_reg, latch_next;
    logic             div_done;

    // Shift register advanced by one bit toward HEAD. It is a rotate so every
    // stored bit has a reader; the wrapped bit is never transmitted because
    // the frame ends after WIDTH bits.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_adv
            if (MSB_FIRST != 0) begin : g_msb
                assign shreg_adv[gi] = shreg_reg[(gi + WIDTH - 1) % WIDTH];
            end else begin : g_lsb
                assign shreg_adv[gi] = shreg_reg[(gi + 1) % WIDTH];
            end
        end
    endgenerate

    assign div_done = (div_cnt_reg == DIV_LAST);

    // Next-state and next-output logic for the IDLE/SHIFT/LATCH sequencer
    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        bit_cnt_next = bit_cnt_reg;
        div_cnt_next = div_cnt_reg;
        ready_next   = ready_reg;
        busy_next    = busy_reg;
        sdata_next   = sdata_reg;
        sclk_next    = sclk_reg;
        latch_next   = latch_reg;

        case (state_reg)
            IDLE: begin
                if (bus.valid && ready_reg) begin
                    state_next   = SHIFT;
                    shreg_next   = bus.data_in;
                    sdata_next   = bus.data_in[HEAD];
                    ready_next   = 1'b0;
                    busy_next    = 1'b1;
                    sclk_next    = 1'b0;
                    bit_cnt_next = '0;
                    div_cnt_next = '0;
                end
            end
            SHIFT: begin
                if (div_done) begin
                    div_cnt_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        // sclk falling: either move to the next bit or end the frame
                        sclk_next = 1'b0;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next = LATCH;
                            latch_next = 1'b1;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                            shreg_next   = shreg_adv;
                            sdata_next   = shreg_adv[HEAD];
                        end
                    end
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            LATCH: begin
                if (div_done) begin
                    state_next   = IDLE;
                    latch_next   = 1'b0;
                    sdata_next   = 1'b0;
                    busy_next    = 1'b0;
                    ready_next   = 1'b1;
                    div_cnt_next = '0;
                    bit_cnt_next = '0;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without a latch pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            sdata_reg   <= 1'b0;
            sclk_reg    <= 1'b0;
            latch_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= bit_cnt_next;
            div_cnt_reg <= div_cnt_next;
            ready_reg   <= ready_next;
            busy_reg    <= busy_next;
            sdata_reg   <= sdata_next;
            sclk_reg    <= sclk_next;
            latch_reg   <= latch_next;
        end
    end

    assign bus.ready = ready_reg;
    assign bus.busy  = busy_reg;
    assign bus.sdata = sdata_reg;
    assign bus.sclk  = sclk_reg;
    assign bus.latch = latch_reg;
endmodule

// File: doc/shift_chain_tx.md
Name: shift_chain_tx

Overview:
- Parallel-in/serial-out transmitter that drives a chain of D flip-flops (SIPO receiver) from the write side.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out on sdata with a generated sclk strobe; the receiver flip-flops capture on sclk rising edges.
- Ends each frame with a latch pulse so the receiver can transfer the chain contents to its parallel output.

Parameters:
WIDTH, 8, bits per frame; legal range >= 1.
DIV, 2, clk cycles per sclk half-period; legal range >= 1.
MSB_FIRST, 1, 1 = bit WIDTH-1 shifted first; 0 = bit 0 shifted first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active high.
data_in  input  WIDTH  word to transmit; sampled only on accept.
valid  input  1  producer has a word on data_in.
ready  output  1  transmitter idle and able to accept.
sdata  output  1  serial data to the receiver chain D input.
sclk  output  1  shift strobe to the receiver chain clock input.
latch  output  1  end-of-frame strobe for the receiver's parallel register.
busy  output  1  frame in progress (SHIFT or LATCH state).

Behaviour:
- One clock domain (clk). rst is synchronous and active high.
- All outputs are registered.
- Reset values: ready=1, busy=0, sdata=0, sclk=0, latch=0, state=IDLE, bit and divider counters = 0.
- States: IDLE, SHIFT, LATCH.
- IDLE:
  - ready=1, sclk=0, latch=0, sdata=0.
  - Accept occurs at a clk edge T where valid=1 and ready=1.
  - At edge T, data_in is loaded into the shift register and the state moves to SHIFT.
  - Also at edge T: ready=0, busy=1, sdata = first bit (MSB or LSB per MSB_FIRST), sclk=0, counters=0.
- SHIFT:
  - Each bit occupies 2*DIV cycles: sclk=0 for DIV cycles, then sclk=1 for DIV cycles.
  - Bit k (k = 0..WIDTH-1): sclk rises at edge T+(2k+1)*DIV and falls at edge T+(2k+2)*DIV.
  - sdata changes only on sclk-falling edges (and at accept). It is stable for DIV cycles before and DIV cycles after every sclk rise.
  - At the sclk fall ending bit k < WIDTH-1, sdata takes bit k+1.
  - At the sclk fall ending the last bit (edge T+2*DIV*WIDTH): state moves to LATCH, latch=1, and sdata holds the last bit.
- LATCH:
  - latch=1 and sclk=0 for exactly DIV cycles.
  - At edge T+2*DIV*WIDTH+DIV: latch=0, sdata=0, busy=0, ready=1, state returns to IDLE.
- Timing:
  - ready is low for exactly 2*DIV*WIDTH+DIV cycles per frame.
  - Exactly WIDTH sclk rising edges per frame.
- Back-to-back frames:
  - With valid held high, the next accept occurs on the edge after ready returns high.
  - ready is therefore high for exactly 1 cycle between frames.
  - A new frame never overlaps a latch pulse.
- Handshake rules:
  - valid and data_in are ignored while ready=0.
  - data_in changes after accept do not affect the frame in progress.
  - valid is not required to stay high after accept.
- Reset mid-frame:
  - rst=1 at any edge forces all reset values at that edge.
  - The frame is aborted with no latch pulse.
  - rst has priority over an accept at the same edge.
- Internal counters: bit counter ceil(log2(WIDTH+1)) bits, divider counter ceil(log2(DIV+1)) bits. No wrap-around is visible outside a frame.

Test Plan:
- WIDTH=8, DIV=2, MSB_FIRST=1, send 0xA5 into a bench SIPO of 8 chained D flip-flops. Required:
  - sdata at sclk rises = 1,0,1,0,0,1,0,1.
  - 8 sclk pulses, each 2 cycles high.
  - latch high 2 cycles; receiver parallel register = 0xA5.
  - ready low for 34 cycles.
- MSB_FIRST=0, send 0x01 -> sdata at sclk rises = 1,0,0,0,0,0,0,0; receiver register = 0x01.
- valid held high with 0x3C then 0xC3 queued -> receiver registers 0x3C then 0xC3; ready high exactly 1 cycle between frames; no sclk edge while latch=1.
- Toggle valid and randomize data_in during a 0x5A frame -> transmitted word remains 0x5A; no extra accept.
- Assert rst for 1 cycle after the 3rd sclk rise -> at that edge sclk=0, sdata=0, latch=0, busy=0, ready=1; no latch pulse; a following 0xFF frame is received correctly.
- WIDTH=1, DIV=1, send 1 -> sclk high 1 cycle at T+1; latch high at T+2; ready back at T+3 (ready low 3 cycles).
